// File: rtl/design_switch_pkg.sv
// design_switch_pkg: register offsets, CTRL field positions and switch FSM states
// shared by the design switch and its Wishbone register file.
package design_switch_pkg;

  // Register index taken from wbs_adr_i[3:2]
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_COUNTER  = 2'd1;
  localparam logic [1:0] REG_SETTINGS = 2'd2;
  localparam logic [1:0] REG_GAP      = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_OVR_ACT     = 0;
  localparam int CTRL_OVR_RST     = 1;
  localparam int CTRL_SEL_LSB     = 2;
  localparam int CTRL_SEL_W       = 5;
  localparam int CTRL_SEL_INVALID = 30;
  localparam int CTRL_BUSY        = 31;

  // Switch sequencing: pads quiet while draining the old design and settling the new one
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } sw_state_t;

endpackage

// File: rtl/design_switch_if.sv
// design_switch_if: Wishbone slave bus between the host and the design switch.
interface design_switch_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/design_switch_wb_regs.sv
// dsw_wb_regs: Wishbone register file (CTRL, COUNTER, SETTINGS, GAP) with
// single-cycle ack. The select field itself lives in the top-level FSM; this
// block only reports CTRL writes to it.
// Build option: DSW_COUNTER_EN adds a free-running, writable 32-bit COUNTER;
// without it COUNTER reads 0 and has no flops.
module dsw_wb_regs
  import design_switch_pkg::*;
#(
  parameter int GAP_RST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  design_switch_if.slave wb,
  input  logic [4:0]    select,
  input  logic          busy,
  input  logic          sel_invalid,
  output logic          ctrl_wr,
  output logic [4:0]    ctrl_wr_sel,
  output logic          ovr_act,
  output logic          ovr_rst,
  output logic [7:0]    gap,
  output logic [31:0]   custom_settings
);

  logic        req;
  logic        wr;
  logic [1:0]  reg_sel;
  logic [31:0] rd_data;
  logic [31:0] counter;
  logic        unused_adr;

  assign req         = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o;
  assign wr          = req & wb.wbs_we_i;
  assign reg_sel     = wb.wbs_adr_i[3:2];
  assign ctrl_wr     = wr && (reg_sel == REG_CTRL);
  assign ctrl_wr_sel = wb.wbs_dat_i[CTRL_SEL_LSB +: CTRL_SEL_W];
  assign unused_adr  = ^{wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0]};

`ifdef DSW_COUNTER_EN
  // Free-running counter; a host write wins over the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
    end else if (wr && (reg_sel == REG_COUNTER)) begin
      counter <= wb.wbs_dat_i;
    end else begin
      counter <= counter + 32'd1;
    end
  end
`else
  assign counter = '0;
`endif

  // Read mux; bits without a field read as zero
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL: begin
        rd_data[CTRL_OVR_ACT]                    = ovr_act;
        rd_data[CTRL_OVR_RST]                    = ovr_rst;
        rd_data[CTRL_SEL_LSB +: CTRL_SEL_W]      = select;
        rd_data[CTRL_SEL_INVALID]                = sel_invalid;
        rd_data[CTRL_BUSY]                       = busy;
      end
      REG_COUNTER:  rd_data = counter;
      REG_SETTINGS: rd_data = custom_settings;
      default:      rd_data = {24'd0, gap};
    endcase
  end

  // Ack, read data and register writes all land on the edge that raises ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.wbs_ack_o    <= 1'b0;
      wb.wbs_dat_o    <= '0;
      ovr_act         <= 1'b0;
      ovr_rst         <= 1'b1;
      gap             <= 8'(GAP_RST);
      custom_settings <= '0;
    end else begin
      wb.wbs_ack_o <= req;
      if (req) begin
        wb.wbs_dat_o <= rd_data;
      end
      if (wr) begin
        case (reg_sel)
          REG_CTRL: begin
            ovr_act <= wb.wbs_dat_i[CTRL_OVR_ACT];
            ovr_rst <= wb.wbs_dat_i[CTRL_OVR_RST];
          end
          REG_SETTINGS: custom_settings <= wb.wbs_dat_i;
          REG_GAP:      gap             <= wb.wbs_dat_i[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/design_switch.sv
// design_switch: connects one of N_DESIGNS user designs to the pads. A select
// change goes through DRAIN and SETTLE phases (GAP cycles each, minimum one)
// with every design in reset and the pads tri-stated.
// Build option: DSW_COUNTER_EN enables the COUNTER register in dsw_wb_regs.
module design_switch
  import design_switch_pkg::*;
#(
  parameter int N_DESIGNS = 8,
  parameter int IO_W      = 33,
  parameter int RSV       = 5,
  parameter int GAP_RST   = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  design_switch_if.slave            wb,
  input  logic [RSV+IO_W-1:0]       io_in,
  output logic [RSV+IO_W-1:0]       io_out,
  output logic [RSV+IO_W-1:0]       io_oeb,
  input  logic [N_DESIGNS*IO_W-1:0] design_do,
  input  logic [N_DESIGNS*IO_W-1:0] design_oeb,
  output logic [N_DESIGNS-1:0]      design_rst,
  output logic [31:0]               custom_settings
);

  sw_state_t  state;
  logic [4:0] select;
  logic [4:0] pending;
  logic [7:0] gap_lat;
  logic [7:0] cnt;
  logic [7:0] last;
  logic       busy;
  logic       sel_invalid;
  logic       route;
  logic       rst_val;
  logic       ctrl_wr;
  logic [4:0] ctrl_wr_sel;
  logic       ovr_act;
  logic       ovr_rst;
  logic [7:0] gap;
  logic       unused_io;

  dsw_wb_regs #(
    .GAP_RST(GAP_RST)
  ) u_regs (
    .clk            (wb_clk_i),
    .rst_n          (wb_rst_ni),
    .wb             (wb),
    .select         (select),
    .busy           (busy),
    .sel_invalid    (sel_invalid),
    .ctrl_wr        (ctrl_wr),
    .ctrl_wr_sel    (ctrl_wr_sel),
    .ovr_act        (ovr_act),
    .ovr_rst        (ovr_rst),
    .gap            (gap),
    .custom_settings(custom_settings)
  );

  assign last        = (gap_lat == 8'd0) ? 8'd0 : gap_lat - 8'd1;
  assign sel_invalid = {27'd0, select} >= 32'(N_DESIGNS);
  assign route       = wb_rst_ni && !busy && !sel_invalid;
  assign rst_val     = ovr_act ? ovr_rst : io_in[0];
  assign unused_io   = ^io_in[RSV+IO_W-1:1];

  // Switch sequencer; GAP is captured at the start so mid-switch GAP writes wait for the next switch
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= ST_ACTIVE;
      select  <= '0;
      pending <= '0;
      gap_lat <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (ctrl_wr && (ctrl_wr_sel != select)) begin
            pending <= ctrl_wr_sel;
            gap_lat <= gap;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cnt >= last) begin
            select <= pending;
            cnt    <= '0;
            state  <= ST_SETTLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt >= last) begin
            busy  <= 1'b0;
            state <= ST_ACTIVE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_ACTIVE;
        end
      endcase
    end
  end

  // Pad mux: only the selected valid design reaches the pads, reserved pads stay inputs
  always_comb begin
    design_rst = '1;
    io_out     = '0;
    io_oeb     = '1;
    for (int i = 0; i < N_DESIGNS; i++) begin
      if (route && (select == 5'(i))) begin
        design_rst[i]         = rst_val;
        io_out[RSV +: IO_W]   = design_do[i*IO_W +: IO_W];
        io_oeb[RSV +: IO_W]   = design_oeb[i*IO_W +: IO_W];
      end
    end
  end

endmodule

// File: doc/design_switch.md
DESIGN_SWITCH -- requirements
Module: design_switch

Interface
REQ-001 SHALL have parameter N_DESIGNS, default 8, number of selectable designs (2..32).
REQ-002 SHALL have parameter IO_W, default 33, pad lanes per design.
REQ-003 SHALL have parameter RSV, default 5, low pads reserved as inputs.
REQ-004 SHALL have parameter GAP_RST, default 16, reset value of the switch-gap register.
REQ-005 SHALL have port wb_clk_i, input, 1 bit, the single clock.
REQ-006 SHALL have port wb_rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have Wishbone ports wbs_cyc_i, wbs_stb_i, wbs_we_i (in, 1), wbs_adr_i and wbs_dat_i (in, 32), wbs_dat_o (out, 32), wbs_ack_o (out, 1).
REQ-008 SHALL have io_in (in), io_out (out) and io_oeb (out), each RSV+IO_W bits wide, connecting to the pads.
REQ-009 SHALL have design_do and design_oeb, inputs, N_DESIGNS*IO_W bits each; design i occupies slice [i*IO_W +: IO_W].
REQ-010 SHALL have design_rst, output, N_DESIGNS bits; 1 holds that design in reset.
REQ-011 SHALL have custom_settings, output, 32 bits, a register copy.

Function
REQ-012 SHALL decode registers on wbs_adr_i[3:2]: 0 CTRL, 1 COUNTER, 2 SETTINGS, 3 GAP.
REQ-013 SHALL map CTRL as [0] ovr_act, [1] ovr_rst, [6:2] select (read/write), [30] sel_invalid (RO) and [31] busy (RO).
REQ-014 SHALL raise wbs_ack_o one cycle after cyc&stb is sampled with ack low, hold it for one cycle only, and apply the write on the ack cycle.
REQ-015 SHALL load wbs_dat_o on the ack cycle; unmapped bits read 0.
REQ-016 SHALL run an FSM with states ACTIVE, DRAIN and SETTLE; reset state is ACTIVE.
REQ-017 SHALL, on a CTRL write whose select differs from the current select while in ACTIVE, store it as pending and move to DRAIN.
REQ-018 SHALL, in DRAIN and SETTLE, hold all design_rst bits at 1, drive all io_oeb bits to 1, drive io_out to 0, and read busy=1.
REQ-019 SHALL stay in DRAIN for GAP cycles, then commit pending to select and enter SETTLE.
REQ-020 SHALL stay in SETTLE for GAP cycles, then return to ACTIVE; GAP=0 means 1 cycle in each state.
REQ-021 SHALL ignore the select field of a CTRL write received while busy, still apply ovr_act/ovr_rst, and still acknowledge it.
REQ-022 SHALL, in ACTIVE, drive design_rst[select] = ovr_act ? ovr_rst : io_in[0], and hold every other bit at 1.
REQ-023 SHALL, in ACTIVE with select < N_DESIGNS, route io_out[RSV+:IO_W] and io_oeb[RSV+:IO_W] from that design's slices.
REQ-024 SHALL, when select >= N_DESIGNS, hold all design_rst at 1, io_out at 0 and io_oeb at all 1, and read sel_invalid=1.
REQ-025 SHALL always drive io_out[RSV-1:0]=0 and io_oeb[RSV-1:0]=1.
REQ-026 SHALL use the GAP register, 8 bits, with writes to it taking effect at the next switch.

Reset
REQ-027 SHALL, while wb_rst_ni=0, asynchronously force: FSM ACTIVE, select=0, ovr_act=0, ovr_rst=1, SETTINGS=0, GAP=GAP_RST, COUNTER=0, wbs_ack_o=0, wbs_dat_o=0, design_rst all 1, io_oeb all 1, io_out 0.
REQ-028 SHALL, when reset is asserted mid-switch, discard the pending select.

Configuration
REQ-029 SHALL, with DSW_COUNTER_EN defined, make COUNTER a free-running 32-bit wrapping counter that is writable, with the write winning over the increment.
REQ-030 SHALL, without DSW_COUNTER_EN, make COUNTER read 0, ignore writes to it, and synthesise no counter flops.

Structure
REQ-031 SHALL place register offsets, CTRL bit positions and the FSM state enum in package design_switch_pkg.
REQ-032 SHALL implement the Wishbone register file plus ack logic as sub-module dsw_wb_regs, with the FSM and pad mux in the top level.

Verification
REQ-033 SHALL verify: after reset, a CTRL read returns 0x00000002, all design_rst are 1, and io_oeb is all 1.
REQ-034 SHALL verify: CTRL write 0x0C (select 3) with GAP=4 gives busy for 8 cycles, design 3 pads routed afterwards, and design_rst=~(1<<3) with io_in[0]=0.
REQ-035 SHALL verify: a CTRL write of select 5 during busy leaves select at 3 and still returns an ack.
REQ-036 SHALL verify: select 31 with N_DESIGNS=8 gives sel_invalid=1, io_oeb all 1, and design_rst all 1.
REQ-037 SHALL verify: ovr_act=1 with ovr_rst=0 releases the selected reset regardless of io_in[0].
REQ-038 SHALL verify: with DSW_COUNTER_EN, writing 0xFFFFFFFF to COUNTER and then reading it shows wrap to a small value; without DSW_COUNTER_EN it reads 0.
